// File: rtl/seq_div_unit.sv
// Multicycle unsigned restoring divider, one quotient bit per RUN cycle.
// Optional signed support (is_signed port, FIXUP state) under `SEQ_DIV_SIGNED_EN.
module seq_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SEQ_DIV_SIGNED_EN
  input  logic             is_signed,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

`ifdef SEQ_DIV_SIGNED_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] qr_q, qr_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             zero_q, zero_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
`ifdef SEQ_DIV_SIGNED_EN
  logic             sgn_q, sgn_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] mag_a, mag_b;
`endif

  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic             no_borrow;

  // Shifting the whole R reads every bit; equals {R[WIDTH-1:0], Qreg[MSB]}.
  always_comb begin
    r_shift = (r_q << 1) | {{WIDTH{1'b0}}, qr_q[WIDTH-1]};
    {no_borrow, trial} = {1'b0, r_shift} + {1'b0, ~{1'b0, divisor_q}} + {{(WIDTH+1){1'b0}}, 1'b1};
  end

  always_comb begin
    state_d     = state_q;
    divisor_d   = divisor_q;
    qr_d        = qr_q;
    r_d         = r_q;
    cnt_d       = cnt_q;
    zero_d      = zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
    sgn_d       = sgn_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    mag_a       = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    mag_b       = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          zero_d = (divisor == '0);
          r_d    = '0;
          cnt_d  = CW'(WIDTH - 1);
          dbz_d  = 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
          // Divide by zero keeps the raw dividend so it can be returned as remainder.
          qr_d      = (divisor == '0) ? dividend : mag_a;
          divisor_d = mag_b;
          sgn_d     = is_signed;
          neg_quo_d = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_rem_d = is_signed && dividend[WIDTH-1];
`else
          qr_d      = dividend;
          divisor_d = divisor;
`endif
          state_d = (divisor == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        r_d   = no_borrow ? trial : r_shift;
        qr_d  = {qr_q[WIDTH-2:0], no_borrow};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) begin
`ifdef SEQ_DIV_SIGNED_EN
          state_d = sgn_q ? S_FIXUP : S_DONE;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef SEQ_DIV_SIGNED_EN
      S_FIXUP: begin
        if (neg_quo_q) qr_d = -qr_q;
        if (neg_rem_q) r_d = {1'b0, -r_q[WIDTH-1:0]};
        state_d = S_DONE;
      end
`endif
      S_DONE: begin
        done_d = 1'b1;
        if (zero_q) begin
          quotient_d  = '1;
          remainder_d = qr_q;
          dbz_d       = 1'b1;
        end else begin
          quotient_d  = qr_q;
          remainder_d = r_q[WIDTH-1:0];
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      divisor_q   <= '0;
      qr_q        <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
      zero_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      sgn_q       <= 1'b0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      divisor_q   <= divisor_d;
      qr_q        <= qr_d;
      r_q         <= r_d;
      cnt_q       <= cnt_d;
      zero_q      <= zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
`ifdef SEQ_DIV_SIGNED_EN
      sgn_q       <= sgn_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
`endif
    end
  end

`ifdef SEQ_DIV_SIGNED_EN
  assign busy = (state_q == S_RUN) || (state_q == S_FIXUP);
`else
  assign busy = (state_q == S_RUN);
`endif
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_unit.sv
// Directed and random checks of seq_div_unit against an arithmetic reference model.
module tb_seq_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] quotient, remainder;

  int n_checks = 0;
  int n_fail = 0;

  seq_div_unit #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
`ifdef SEQ_DIV_SIGNED_EN
    .is_signed(is_signed),
`endif
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .quotient(quotient),
    .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sg,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z, output int lat);
    z = 1'b0;
    if (b == 0) begin
      q = '1; r = a; z = 1'b1; lat = 1;
    end else if (!sg) begin
      q = a / b; r = a % b; lat = W + 1;
    end else begin
      lat = W + 2;
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000; r = '0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end
  endfunction

  task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic sg, input int inject);
    logic [W-1:0] eq, er;
    logic ez;
    int elat, cycles, lat;
    model(a, b, sg, eq, er, ez, elat);
    @(negedge clk);
    dividend = a; divisor = b; is_signed = sg; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " busy_after_start"}, 64'(busy), 64'(b != 0));
    cycles = 0; lat = -1;
    while (cycles < 200 && lat < 0) begin
      if (cycles == inject && inject > 0) begin
        start = 1'b1; dividend = 50; divisor = 5;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cycles++;
      if (done) lat = cycles;
    end
    start = 1'b0;
    chk({tag, " latency"}, 64'(lat), 64'(elat));
    chk({tag, " quotient"}, 64'(quotient), 64'(eq));
    chk({tag, " remainder"}, 64'(remainder), 64'(er));
    chk({tag, " div_by_zero"}, 64'(div_by_zero), 64'(ez));
    chk({tag, " busy_at_done"}, 64'(busy), 64'(0));
    @(posedge clk); #1;
    chk({tag, " done_single_pulse"}, 64'(done), 64'(0));
    chk({tag, " quotient_held"}, 64'(quotient), 64'(eq));
  endtask

  initial begin
    int dones;
    logic [W-1:0] a, b;
    logic sg;

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset quotient", 64'(quotient), 64'(0));
    chk("reset remainder", 64'(remainder), 64'(0));
    chk("reset dbz", 64'(div_by_zero), 64'(0));

    run("100/7", 100, 7, 1'b0, 0);
    run("5/0", 5, 0, 1'b0, 0);
    run("9/3", 9, 3, 1'b0, 0);
    run("max/1", 32'hFFFF_FFFF, 1, 1'b0, 0);
    run("3/10", 3, 10, 1'b0, 0);
    run("100/7 ignore_start", 100, 7, 1'b0, 10);

    // Reset in the middle of a division aborts it without a done pulse.
    @(negedge clk);
    dividend = 100; divisor = 7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst busy", 64'(busy), 64'(0));
    chk("midrst done", 64'(done), 64'(0));
    chk("midrst quotient", 64'(quotient), 64'(0));
    chk("midrst remainder", 64'(remainder), 64'(0));
    chk("midrst dbz", 64'(div_by_zero), 64'(0));
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    chk("midrst no_done", 64'(dones), 64'(0));
    run("20/6", 20, 6, 1'b0, 0);

`ifdef SEQ_DIV_SIGNED_EN
    run("s -7/2", 32'hFFFF_FFF9, 2, 1'b1, 0);
    run("s min/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    run("s -5/0", 32'hFFFF_FFFB, 0, 1'b1, 0);
`endif

    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      case (i % 4)
        0: b = $urandom;
        1: b = $urandom_range(1, 255);
        2: b = (i == 6) ? '0 : (a >> $urandom_range(0, 31));
        default: b = $urandom_range(1, 65535);
      endcase
`ifdef SEQ_DIV_SIGNED_EN
      sg = 1'($urandom_range(0, 1));
`else
      sg = 1'b0;
`endif
      run($sformatf("rand%0d %0h/%0h", i, a, b), a, b, sg, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/seq_div_unit.md
Name: seq_div_unit

Overview:
- Multicycle unsigned restoring divider for the ALU datapath.
- Consumes ripple-borrow subtract results each cycle: trial remainder minus divisor, carry-out as no-borrow flag.
- Started by the multicycle controller; results held for write-back.
- One quotient bit per cycle; start/done handshake.

Parameters:
- WIDTH, 32, operand/result width in bits (≥2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request division; sampled only in IDLE.
- dividend  input  WIDTH  numerator; captured when start accepted.
- divisor  input  WIDTH  denominator; captured when start accepted.
- busy  output  1  high in RUN (and FIXUP if enabled).
- done  output  1  one-cycle pulse when results become valid.
- quotient  output  WIDTH  result quotient; held until next accepted start.
- remainder  output  WIDTH  result remainder; held until next accepted start.
- div_by_zero  output  1  set with done when captured divisor = 0; held with results.

Behaviour:
- Reset (rst=1 at clock edge): state=IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0; internal regs and counter cleared. Applies mid-operation: any in-flight division is aborted, no done.
- States: IDLE, RUN, DONE (plus FIXUP under optional feature).
- IDLE: start=1 → capture operands, clear partial remainder R (WIDTH+1 bits), counter=WIDTH-1.
  - Divisor≠0 → RUN.
  - Divisor=0 → DONE.
- RUN, each cycle:
  - R' = {R[WIDTH-1:0], Qreg[MSB]}; Qreg shifted left.
  - Trial D = R' + ~{1'b0,divisor} + 1, computed in WIDTH+1 bits.
  - Carry-out=1 (no borrow) → R=D, Qreg[0]=1; else R=R', Qreg[0]=0.
  - Counter decrements; exits to DONE after the cycle where counter=0 (exactly WIDTH RUN cycles).
- DONE (one cycle): quotient=Qreg, remainder=R[WIDTH-1:0], done=1, busy=0; next state IDLE.
- Divide by zero: quotient={WIDTH{1'b1}}, remainder=dividend, div_by_zero=1.
- Latency:
  - Start accepted at edge N → done high in cycle N+WIDTH+1.
  - Divide by zero → done in cycle N+1.
- Back-to-back: start asserted in the cycle after done is accepted (controller is already IDLE).
- start while busy or in DONE: ignored; no re-capture, operands must not be re-sampled.
- div_by_zero cleared on the next accepted start.
- Dividend < divisor → quotient=0, remainder=dividend.
- No overflow possible in the unsigned path.

Optional Feature:
- Macro: SEQ_DIV_SIGNED_EN.
- Defined: adds input port is_signed (1 bit, sampled with start).
  - When is_signed=1, operands are converted to magnitudes at capture and sign flags are stored.
  - After RUN, FIXUP state (one cycle, busy=1) negates: quotient if operand signs differ; remainder if dividend negative.
  - Latency becomes WIDTH+2 for is_signed=1; unchanged for is_signed=0.
  - Most-negative/−1: quotient=most-negative (wraps), remainder=0, no flag.
  - Signed divide by zero: same results as unsigned divide by zero (raw dividend as remainder).
- Undefined: no is_signed port, no FIXUP state, unsigned only.

Test Plan:
- WIDTH=32, start with dividend=100, divisor=7 → done exactly 33 cycles after start edge; quotient=14, remainder=2, div_by_zero=0.
- dividend=5, divisor=0 → done 1 cycle after start; quotient=0xFFFFFFFF, remainder=5, div_by_zero=1; next start with 9/3 clears flag, quotient=3, remainder=0.
- 0xFFFFFFFF/1 → quotient=0xFFFFFFFF, remainder=0. Then 3/10 → quotient=0, remainder=3.
- Start 100/7, pulse start with 50/5 at cycle 10 → ignored; results 14/2 at cycle 33, single done pulse.
- Start 100/7, assert rst at cycle 15 → next cycle busy=0, outputs 0, no done; fresh start 20/6 → quotient=3, remainder=2.
- SEQ_DIV_SIGNED_EN, is_signed=1:
  - −7/2 → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF, done at cycle 34.
  - 0x80000000/0xFFFFFFFF → quotient=0x80000000, remainder=0.
